// File: rtl/lifo_port_arbiter_pkg.sv
// Shared constants, response flag layout and sizing helper for the LIFO port arbiter.
package lifo_arb_pkg;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_ERR_CNT_W = 16;

  // Response flags registered at the grant edge
  typedef struct packed {
    logic valid;
    logic err;
    logic is_pop;
  } rsp_flags_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lifo_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from last winner + 1; pointer moves only on a grant.
module rr_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ID_W    = id_width(DEF_NUM_REQ)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    idx_c,
  output logic               any_c
);

  logic [ID_W-1:0] ptr;

  // Walk candidates from farthest to nearest so the nearest request wins the last write
  always_comb begin
    int j;
    j       = 0;
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    if (!hold) begin
      for (int k = int'(NUM_REQ); k >= 1; k--) begin
        j = int'(ptr) + k;
        if (j >= int'(NUM_REQ)) j = j - int'(NUM_REQ);
        if (req[ID_W'(j)]) begin
          idx_c = ID_W'(j);
          any_c = 1'b1;
        end
      end
    end
    if (any_c) grant_c = NUM_REQ'(1) << idx_c;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)     ptr <= ID_W'(NUM_REQ - 1);
    else if (any_c) ptr <= idx_c;
  end

endmodule

// File: rtl/lifo_port_arbiter.sv
// Shares one LIFO among NUM_REQ requesters with round-robin grants and tagged 1-cycle responses.
// Optional rejected-op counter on err_count when LIFO_ARB_ERR_CNT_EN is defined.
module lifo_port_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = DEF_DATA_W,
  parameter int unsigned  NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned  ERR_CNT_W  = DEF_ERR_CNT_W,
  localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          lifo_push,
  output logic                          lifo_pop,
  output logic [DATA_WIDTH-1:0]         lifo_din,
  input  logic [DATA_WIDTH-1:0]         lifo_dout,
  input  logic                          lifo_empty,
  input  logic                          lifo_full
`ifdef LIFO_ARB_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]          err_count
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || ERR_CNT_W == 0) begin : g_bad_params
    $error("lifo_port_arbiter: NUM_REQ must be 2..16 and ERR_CNT_W nonzero");
  end

  logic [NUM_REQ-1:0]    grant_c;
  logic [ID_W-1:0]       gidx_c;
  logic                  any_c;
  logic                  op_c;
  logic                  err_c;
  logic [DATA_WIDTH-1:0] gdata_c;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  rsp_flags_t            rsp_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .req     (req_valid),
    .hold    (hold),
    .grant_c (grant_c),
    .idx_c   (gidx_c),
    .any_c   (any_c)
  );

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_slice
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req_ready = grant_c;
  assign op_c      = req_op[gidx_c];
  assign gdata_c   = data_arr[gidx_c];

  // FULL/EMPTY are sampled in the grant cycle; a blocked op becomes an error response
  always_comb begin
    lifo_push = 1'b0;
    lifo_pop  = 1'b0;
    lifo_din  = '0;
    err_c     = 1'b0;
    if (any_c) begin
      if (op_c == OP_PUSH) begin
        if (!lifo_full) begin
          lifo_push = 1'b1;
          lifo_din  = gdata_c;
        end else begin
          err_c = 1'b1;
        end
      end else begin
        if (!lifo_empty) lifo_pop = 1'b1;
        else             err_c    = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rsp_q  <= '0;
      rsp_id <= '0;
    end else begin
      rsp_q.valid  <= any_c;
      rsp_q.err    <= err_c;
      rsp_q.is_pop <= any_c & (op_c == OP_POP);
      if (any_c) rsp_id <= gidx_c;
    end
  end

  assign rsp_valid = rsp_q.valid;
  assign rsp_err   = rsp_q.err;
  // LIFO registers its output on the grant edge, so it lines up with the response cycle
  assign rsp_data  = (rsp_q.valid && rsp_q.is_pop && !rsp_q.err) ? lifo_dout : '0;

`ifdef LIFO_ARB_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                           err_cnt_q <= '0;
    else if (err_c && (err_cnt_q != '1))  err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
  end

  assign err_count = err_cnt_q;
`endif

endmodule
